datapath_ctrl: RTL

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/datapath_ctrl_pkg.sv | 49 ++++
 rtl/datapath_ctrl_timer.sv | 41 ++++
 rtl/datapath_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_pkg.sv
// ============================================================================
//  Module      : datapath_ctrl_pkg
//  Description : Shared types, opcodes and instruction field positions for
//                the datapath controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package datapath_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WAITF = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU      = 2'b00,
        CLS_LOAD     = 2'b01,
        CLS_WAITFLAG = 2'b10,
        CLS_NOP      = 2'b11
    } class_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;

    localparam int c_instr_w  = 18;
    localparam int c_cls_hi   = 17;
    localparam int c_cls_lo   = 16;
    localparam int c_op_hi    = 15;
    localparam int c_op_lo    = 13;
    localparam int c_rsvd_bit = 12;
    localparam int c_wa_hi    = 11;
    localparam int c_wa_lo    = 8;
    localparam int c_raa_hi   = 7;
    localparam int c_raa_lo   = 4;
    localparam int c_rab_hi   = 3;
    localparam int c_rab_lo   = 0;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_MOV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/datapath_ctrl_timer.sv
// ============================================================================
//  Module      : flag_timer
//  Description : Counts cycles spent waiting for the datapath flag; expired
//                once the count reaches TIMEOUT.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module flag_timer #(
    parameter int TIMEOUT = 100
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           start,
    input  wire logic                           clear,
    output logic [$clog2(TIMEOUT+1)-1:0]        count,
    output logic                                expired
);

    localparam int                c_cw    = $clog2(TIMEOUT+1);
    localparam logic [c_cw-1:0]   c_limit = c_cw'(TIMEOUT);

    logic [c_cw-1:0] r_count;

    // Saturates at the limit so expired stays asserted until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (start && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count   = r_count;
    assign expired = (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/datapath_ctrl.sv
// ============================================================================
//  Module      : datapath_ctrl
//  Description : Instruction-driven controller producing datapath register
//                selects, opcode and write enable, with a flag-wait timeout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 100
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          instr_valid,
    input  wire logic [17:0]   instr,
    output logic               instr_ready,
    input  wire logic          Flag,
    output logic [2:0]         Op,
    output logic [3:0]         WA,
    output logic [3:0]         RAA,
    output logic [3:0]         RAB,
    output logic [3:0]         Sel,
    output logic               Wen,
    output logic               done,
    output logic               err
);

    localparam int c_cw = $clog2(TIMEOUT+1);

    state_t         r_state;
    state_t         w_next;
    logic           r_nop;
    logic           r_illegal;
    logic [2:0]     r_op;
    logic [3:0]     r_wa;
    logic [3:0]     r_raa;
    logic [3:0]     r_rab;
    logic [3:0]     r_sel;

    logic           w_accept;
    class_t         w_cls;
    logic [2:0]     w_op_f;
    logic [3:0]     w_wa_f;
    logic [3:0]     w_raa_f;
    logic [3:0]     w_rab_f;
    logic           w_wen;
    logic           w_done;
    logic           w_err;
    logic           w_tmr_expired;
    logic [c_cw-1:0] w_unused_tmr_count;
    logic           w_unused_rsvd;

    assign w_cls         = class_t'(instr[c_cls_hi:c_cls_lo]);
    assign w_op_f        = instr[c_op_hi:c_op_lo];
    assign w_wa_f        = instr[c_wa_hi:c_wa_lo];
    assign w_raa_f       = instr[c_raa_hi:c_raa_lo];
    assign w_rab_f       = instr[c_rab_hi:c_rab_lo];
    assign w_unused_rsvd = instr[c_rsvd_bit];

    assign instr_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept    = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath controls only change on accept, so they hold through EXEC/WRITE and in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nop     <= 1'b0;
            r_illegal <= 1'b0;
            r_op      <= 3'b000;
            r_wa      <= 4'd0;
            r_raa     <= 4'd0;
            r_rab     <= 4'd0;
            r_sel     <= 4'd0;
        end else if (w_accept) begin
            r_nop     <= (w_cls == CLS_NOP);
            r_illegal <= (w_cls == CLS_ALU) && !op_is_legal(w_op_f);
            r_sel     <= (w_cls == CLS_LOAD) ? w_raa_f : 4'd0;
            if ((w_cls == CLS_ALU) || (w_cls == CLS_LOAD)) begin
                r_op  <= (w_cls == CLS_LOAD) ? OP_MOV : w_op_f;
                r_wa  <= w_wa_f;
                r_raa <= w_raa_f;
                r_rab <= w_rab_f;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_wen  = 1'b0;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (w_cls == CLS_WAITFLAG) ? ST_WAITF : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_nop) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (r_illegal) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_wen  = 1'b1;
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            ST_WAITF: begin
                // Flag takes priority over a simultaneous timeout.
                if (Flag) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_tmr_expired) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    flag_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_flag_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (r_state == ST_WAITF),
        .clear   (r_state != ST_WAITF),
        .count   (w_unused_tmr_count),
        .expired (w_tmr_expired)
    );

    assign Op   = r_op;
    assign WA   = r_wa;
    assign RAA  = r_raa;
    assign RAB  = r_rab;
    assign Sel  = r_sel;
    assign Wen  = w_wen;
    assign done = w_done;
    assign err  = w_err;

endmodule

`default_nettype wire
